// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through buffer for 16-bit ALU results.
// Each entry holds {op, res, cout, zero}; the zero flag is computed at push.
// Optional statistics counters are enabled by defining ALU_RESULT_FIFO_STATS_EN.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [W-1:0]  in_res,
    input  logic          in_cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_op,
    output logic [W-1:0]  out_res,
    output logic          out_cout,
    output logic          out_zero,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
`ifdef ALU_RESULT_FIFO_STATS_EN
    ,
    output logic [15:0]   push_cnt,
    output logic [15:0]   carry_cnt
`endif
);

    localparam int EW = W + 4;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // True when the captured result is all zeros.
    function automatic logic is_zero(input logic [W-1:0] v);
        return (v == {W{1'b0}});
    endfunction

    logic [EW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] head_s;

    assign full_s    = (count_r == DEPTH_C);
    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign push_s    = in_valid && !full_s;
    assign pop_s     = out_ready && !empty_s;
    assign in_ready  = !full_s;
    assign out_valid = !empty_s;
    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_r;
    assign head_s    = mem_r[rd_ptr_r];

    // Storage write; contents are intentionally left uncleared by reset.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_r[wr_ptr_r] <= {in_op, in_res, in_cout, is_zero(in_res)};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; reset overrides push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation; masked to zero while empty so stale data never leaks.
    always_comb begin
        out_op   = 2'b00;
        out_res  = {W{1'b0}};
        out_cout = 1'b0;
        out_zero = 1'b0;
        if (empty_s) begin
            out_op   = 2'b00;
            out_res  = {W{1'b0}};
            out_cout = 1'b0;
            out_zero = 1'b0;
        end else begin
            out_op   = head_s[EW-1:EW-2];
            out_res  = head_s[W+1:2];
            out_cout = head_s[1];
            out_zero = head_s[0];
        end
    end

`ifdef ALU_RESULT_FIFO_STATS_EN
    logic [15:0] push_cnt_r;
    logic [15:0] carry_cnt_r;

    // Saturating counters of accepted pushes and of pushes carrying cout.
    always_ff @(posedge clk) begin
        if (reset) begin
            push_cnt_r  <= 16'h0000;
            carry_cnt_r <= 16'h0000;
        end else begin
            if (push_s && (push_cnt_r != 16'hFFFF)) begin
                push_cnt_r <= push_cnt_r + 16'd1;
            end else begin
                push_cnt_r <= push_cnt_r;
            end
            if (push_s && in_cout && (carry_cnt_r != 16'hFFFF)) begin
                carry_cnt_r <= carry_cnt_r + 16'd1;
            end else begin
                carry_cnt_r <= carry_cnt_r;
            end
        end
    end

    assign push_cnt  = push_cnt_r;
    assign carry_cnt = carry_cnt_r;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed testbench for alu_result_fifo (DEPTH=4, W=16).
module tb_alu_result_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_res;
    logic        in_cout;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_op;
    logic [15:0] out_res;
    logic        out_cout;
    logic        out_zero;
    logic [2:0]  count;
    logic        full;
    logic        empty;
`ifdef ALU_RESULT_FIFO_STATS_EN
    logic [15:0] push_cnt;
    logic [15:0] carry_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int exp_push = 0;
    int exp_carry = 0;

    alu_result_fifo #(.DEPTH(4), .AW(2), .W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_res(in_res), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_res(out_res), .out_cout(out_cout), .out_zero(out_zero),
        .count(count), .full(full), .empty(empty)
`ifdef ALU_RESULT_FIFO_STATS_EN
        , .push_cnt(push_cnt), .carry_cnt(carry_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One accepted push, then idle inputs.
    task automatic push_one(input logic [1:0] op, input logic [15:0] res, input logic c);
        in_valid = 1'b1; in_op = op; in_res = res; in_cout = c;
        tick();
        in_valid = 1'b0;
        exp_push++;
        if (c) exp_carry++;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 2'b00; in_res = 16'h0000; in_cout = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
        checks++; if (out_res !== 16'h0000) begin errors++; $display("FAIL reset_out_res got=%h exp=0000", out_res); end
    endtask

    task automatic test_push_single;
        in_valid = 1'b1; in_op = 2'b00; in_res = 16'hFFFF; in_cout = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_fallthrough got=%b exp=0", out_valid); end
        tick();
        in_valid = 1'b0;
        exp_push++;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL push1_valid got=%b exp=1", out_valid); end
        checks++; if (out_res !== 16'hFFFF || out_cout !== 1'b0 || out_zero !== 1'b0 || out_op !== 2'b00)
            begin errors++; $display("FAIL push1_head got res=%h c=%b z=%b op=%b exp FFFF/0/0/00", out_res, out_cout, out_zero, out_op); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL push1_count got=%0d exp=1", count); end
    endtask

    task automatic test_zero_flag;
        push_one(2'b00, 16'h0000, 1'b1);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL zero_count got=%0d exp=2", count); end
        out_ready = 1'b1;
        checks++; if (out_res !== 16'hFFFF || out_zero !== 1'b0) begin errors++; $display("FAIL pop1_head got res=%h z=%b exp FFFF/0", out_res, out_zero); end
        tick();
        checks++; if (out_res !== 16'h0000 || out_cout !== 1'b1 || out_zero !== 1'b1 || out_valid !== 1'b1)
            begin errors++; $display("FAIL pop2_head got res=%h c=%b z=%b v=%b exp 0000/1/1/1", out_res, out_cout, out_zero, out_valid); end
        tick();
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1 || out_res !== 16'h0000 || out_valid !== 1'b0)
            begin errors++; $display("FAIL drain_empty got empty=%b res=%h v=%b exp 1/0000/0", empty, out_res, out_valid); end
    endtask

    task automatic test_full_wrap;
        for (int i = 0; i < 4; i++) push_one(2'(i), 16'h1000 + 16'(i), 1'(i % 2));
        checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4)
            begin errors++; $display("FAIL full_flags got full=%b rdy=%b cnt=%0d exp 1/0/4", full, in_ready, count); end
        in_valid = 1'b1; in_op = 2'b11; in_res = 16'hBEEF; in_cout = 1'b1;
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_drop_count got=%0d exp=4", count); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_no_push got=%0d exp=3", count); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (out_res !== 16'h1000 + 16'(i) || out_op !== 2'(i) || out_cout !== 1'(i % 2))
                begin errors++; $display("FAIL wrap_order[%0d] got res=%h op=%b c=%b exp %h/%0d/%0d", i, out_res, out_op, out_cout, 16'h1000 + 16'(i), i, i % 2); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1 || out_res !== 16'h0000) begin errors++; $display("FAIL wrap_empty got empty=%b res=%h exp 1/0000", empty, out_res); end
    endtask

    task automatic test_back_to_back;
        push_one(2'b01, 16'hC000, 1'b0);
        push_one(2'b01, 16'hC001, 1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_op = 2'b10; in_res = 16'hC002 + 16'(k); in_cout = 1'(k % 2);
            checks++;
            if (out_res !== 16'hC000 + 16'(k)) begin errors++; $display("FAIL b2b_order[%0d] got=%h exp=%h", k, out_res, 16'hC000 + 16'(k)); end
            tick();
            exp_push++;
            if (k % 2 == 1) exp_carry++;
            checks++;
            if (count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=2", k, count); end
        end
        in_valid = 1'b0;
        for (int k = 6; k < 8; k++) begin
            checks++;
            if (out_res !== 16'hC000 + 16'(k) || out_cout !== 1'(k % 2))
                begin errors++; $display("FAIL b2b_tail[%0d] got res=%h c=%b exp %h/%0d", k, out_res, out_cout, 16'hC000 + 16'(k), k % 2); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid;
        push_one(2'b11, 16'hD001, 1'b1);
        push_one(2'b11, 16'hD002, 1'b0);
        push_one(2'b11, 16'hD003, 1'b1);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count got=%0d exp=3", count); end
`ifdef ALU_RESULT_FIFO_STATS_EN
        checks++; if (push_cnt !== 16'(exp_push)) begin errors++; $display("FAIL stats_push got=%0d exp=%0d", push_cnt, exp_push); end
        checks++; if (carry_cnt !== 16'(exp_carry)) begin errors++; $display("FAIL stats_carry got=%0d exp=%0d", carry_cnt, exp_carry); end
`endif
        reset = 1'b1; in_valid = 1'b1; in_res = 16'hD004; in_cout = 1'b1; out_ready = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_res !== 16'h0000)
            begin errors++; $display("FAIL mid_reset got cnt=%0d v=%b res=%h exp 0/0/0000", count, out_valid, out_res); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL mid_reset_flags got e=%b f=%b r=%b exp 1/0/1", empty, full, in_ready); end
`ifdef ALU_RESULT_FIFO_STATS_EN
        checks++; if (push_cnt !== 16'h0000 || carry_cnt !== 16'h0000)
            begin errors++; $display("FAIL stats_reset got push=%0d carry=%0d exp 0/0", push_cnt, carry_cnt); end
`endif
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_reset_hold got=%0d exp=0", count); end
    endtask

    initial begin
        test_reset();
        test_push_single();
        test_zero_flag();
        test_full_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
